// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the instruction fetch unit and its FIFO.
//   FETCH_ADDR_W / FETCH_DATA_W : widths of the fetch entry fields
//   INSTR_BYTES                 : PC increment per fetched instruction
//   NOP_INSTR                   : value shown on instr when nothing is valid
//   fetch_entry_t               : {instr, pc} pair stored per FIFO slot
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam int INSTR_BYTES  = 4;

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry FIFO of fetch_entry_t with same-cycle push/pop and a
// synchronous flush that has priority over push and pop.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   push           : write push_entry at the tail
//   push_entry     : entry to write
//   pop            : drop the head (caller guarantees count != 0)
//   flush          : empty the FIFO and rewind both pointers
//   count          : current number of stored entries (0..DEPTH)
//   head           : entry at the read pointer (meaningless when count == 0)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the top masks head while count == 0.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Consumer side of the Program_Counter: issues a fetch for pc_in each cycle
// there is FIFO credit, tracks the single in-flight response of the
// 1-cycle-latency instruction memory, buffers responses in fetch_fifo and
// presents them to decode with valid/ready. Drives the next PC back.
// Optional build macro: FETCH_STATS_EN adds stat_fetched / stat_stall.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   pc_in               : current PC from Program_Counter
//   pc_next             : next PC to Program_Counter (RESET_PC in reset)
//   imem_req, imem_addr : read strobe and address to instruction memory
//   imem_rdata          : read data, valid the cycle after imem_req
//   redirect            : flush everything and load redirect_target
//   redirect_target     : new PC on redirect
//   instr, instr_pc     : FIFO head (zero when instr_valid = 0)
//   instr_valid         : FIFO non-empty
//   instr_ready         : decode accepts the head this cycle
//   stat_fetched        : saturating pop count (FETCH_STATS_EN only)
//   stat_stall          : saturating full-block cycle count (FETCH_STATS_EN only)
// ADDR_W / DATA_W must equal the fetch_pkg entry widths.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  occupancy;
  logic              full_block;
  logic              issue;
  logic              push;
  logic              pop;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Credit counts the in-flight response; a same-cycle pop gives no credit.
  assign occupancy  = count + CNT_W'(inflight);
  assign full_block = (occupancy == CNT_W'(DEPTH));

  // reset_n is folded in so nothing is requested while reset is asserted.
  assign issue     = reset_n && !redirect && !full_block;
  assign imem_req  = issue;
  assign imem_addr = pc_in;

  always_comb begin
    pc_next = pc_in;
    if (!reset_n)      pc_next = RESET_PC;
    else if (redirect) pc_next = redirect_target;
    else if (issue)    pc_next = pc_in + ADDR_W'(INSTR_BYTES);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc_in;
    end
  end

  // Redirect discards the response landing this cycle and any pop.
  assign push             = inflight && !redirect;
  assign pop              = instr_valid && instr_ready && !redirect;
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head       (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc    : '0;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (pop && (stat_fetched != 32'hFFFF_FFFF))      stat_fetched <= stat_fetched + 32'd1;
      if (full_block && (stat_stall != 32'hFFFF_FFFF)) stat_stall   <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  logic [31:0] pc_reg;
  logic        pc_ovr_en;
  logic [31:0] pc_ovr;

  int vectors;
  int miscompares;

  instr_fetch_unit #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched    (stat_fetched),
    .stat_stall      (stat_stall)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Program_Counter register and 1-cycle instruction memory.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc_reg <= 32'h0;
    else          pc_reg <= pc_next;
  end

  assign pc_in = pc_ovr_en ? pc_ovr : pc_reg;

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    redirect  = 1'b0;
    pc_ovr_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    pc_ovr_en = 1'b1;
    pc_ovr    = 32'h10;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
      vectors++; if (pc_next !== 32'h0) begin miscompares++; $display("FAIL reset_pc_next: got %h want 00000000", pc_next); end
      vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", instr); end
      vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); end
    end
    pc_ovr_en = 1'b0;
    reset_n   = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL release_req: got %b want 1", imem_req); end
    vectors++; if (pc_next !== 32'h4) begin miscompares++; $display("FAIL release_pc_next: got %h want 00000004", pc_next); end
  endtask

  task automatic test_streaming;
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stream_req c%0d: got %b want 1", k, imem_req); end
      vectors++; if (imem_addr !== 32'(4*k)) begin miscompares++; $display("FAIL stream_addr c%0d: got %h want %h", k, imem_addr, 32'(4*k)); end
      vectors++; if (pc_next !== 32'(4*k+4)) begin miscompares++; $display("FAIL stream_pc_next c%0d: got %h want %h", k, pc_next, 32'(4*k+4)); end
      if (k < 2) begin
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL stream_early_valid c%0d: got %b want 0", k, instr_valid); end
      end else begin
        exp_pc = 32'(4*(k-2));
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid c%0d: got %b want 1", k, instr_valid); end
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL stream_instr_pc c%0d: got %h want %h", k, instr_pc, exp_pc); end
        vectors++; if (instr !== (exp_pc ^ 32'hA5A5_0000)) begin miscompares++; $display("FAIL stream_instr c%0d: got %h want %h", k, instr, exp_pc ^ 32'hA5A5_0000); end
      end
      tick();
    end
  endtask

  task automatic test_full_stall;
    int e;
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    for (int j = 0; j < 4; j++) begin
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL full_req c%0d: got %b want 0", j+4, imem_req); end
      vectors++; if (pc_next !== 32'h10) begin miscompares++; $display("FAIL full_pc_next c%0d: got %h want 00000010", j+4, pc_next); end
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid c%0d: got %b want 1", j+4, instr_valid); end
      vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL full_head c%0d: got %h want 00000000", j+4, instr_pc); end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    e = 0;
    for (int t = 0; t < 20 && e < 5; t++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== 32'(4*e)) begin miscompares++; $display("FAIL drain_pc #%0d: got %h want %h", e, instr_pc, 32'(4*e)); end
        vectors++; if (instr !== (32'(4*e) ^ 32'hA5A5_0000)) begin miscompares++; $display("FAIL drain_instr #%0d: got %h want %h", e, instr, 32'(4*e) ^ 32'hA5A5_0000); end
        e++;
      end
      tick();
    end
    vectors++; if (e != 5) begin miscompares++; $display("FAIL drain_timeout: got %0d entries want 5", e); end
  endtask

  task automatic test_redirect;
    instr_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    redirect        = 1'b1;
    redirect_target = 32'h40;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req: got %b want 0", imem_req); end
    vectors++; if (pc_next !== 32'h40) begin miscompares++; $display("FAIL redir_pc_next: got %h want 00000040", pc_next); end
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid_r1: got %b want 0", instr_valid); end
    vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL redir_addr_r1: got %h want 00000040", imem_addr); end
    vectors++; if (pc_next !== 32'h44) begin miscompares++; $display("FAIL redir_pc_next_r1: got %h want 00000044", pc_next); end
    tick();
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid_r2: got %b want 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL redir_valid_r%0d: got %b want 1", k+3, instr_valid); end
      vectors++; if (instr_pc !== 32'(32'h40 + 4*k)) begin miscompares++; $display("FAIL redir_pc_r%0d: got %h want %h", k+3, instr_pc, 32'(32'h40 + 4*k)); end
    end
  endtask

  task automatic test_reset_mid;
    instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", instr_valid); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req: got %b want 0", imem_req); end
    vectors++; if (pc_next !== 32'h0) begin miscompares++; $display("FAIL midrst_pc_next: got %h want 00000000", pc_next); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL midrst_instr: got %h want 00000000", instr); end
    @(negedge clock);
    tick();
    reset_n = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL restart_req: got %b want 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL restart_addr: got %h want 00000000", imem_addr); end
    tick();
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL restart_stale: got %b want 0", instr_valid); end
    tick();
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL restart_valid: got %b want 1", instr_valid); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL restart_pc: got %h want 00000000", instr_pc); end
    vectors++; if (instr !== 32'hA5A5_0000) begin miscompares++; $display("FAIL restart_instr: got %h want a5a50000", instr); end
  endtask

  task automatic test_pc_wrap;
    instr_ready = 1'b1;
    do_reset();
    pc_ovr_en = 1'b1;
    pc_ovr    = 32'hFFFF_FFFC;
    #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL wrap_req: got %b want 1", imem_req); end
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    vectors++; if (pc_next !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_next: got %h want 00000000", pc_next); end
    tick();
    pc_ovr_en = 1'b0;
    #1;
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
    tick();
    vectors++; if (instr_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_head_pc: got %h want fffffffc", instr_pc); end
    vectors++; if (instr !== 32'h5A5A_FFFC) begin miscompares++; $display("FAIL wrap_head_instr: got %h want 5a5afffc", instr); end
    tick();
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_after_pc: got %h want 00000000", instr_pc); end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats;
    instr_ready = 1'b0;
    do_reset();
    vectors++; if (stat_fetched !== 32'h0) begin miscompares++; $display("FAIL stats_reset_fetched: got %0d want 0", stat_fetched); end
    vectors++; if (stat_stall !== 32'h0) begin miscompares++; $display("FAIL stats_reset_stall: got %0d want 0", stat_stall); end
    for (int k = 0; k < 6; k++) tick();
    instr_ready = 1'b1;
    for (int p = 0; p < 10; p++) tick();
    instr_ready = 1'b0;
    #1;
    vectors++; if (stat_fetched !== 32'd10) begin miscompares++; $display("FAIL stats_fetched: got %0d want 10", stat_fetched); end
    vectors++; if (stat_stall !== 32'd3) begin miscompares++; $display("FAIL stats_stall: got %0d want 3", stat_stall); end
  endtask
`endif

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    instr_ready     = 1'b0;
    pc_ovr_en       = 1'b0;
    pc_ovr          = 32'h0;
    imem_rdata      = 32'h0;
    test_reset();
    test_streaming();
    test_full_stall();
    test_redirect();
    test_reset_mid();
    test_pc_wrap();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
